bnn_maxpool_stream: RTL
=======================

BNN_MAXPOOL_STREAM -- requirements
Module: bnn_maxpool_stream

Interface
REQ-001 SHALL provide parameter CH, default 16, number of binary activation channels pooled in parallel (CH >= 1).
REQ-002 SHALL provide parameter POOL, default 4, number of consecutive samples per pooling window (POOL >= 1).
REQ-003 SHALL derive CW = max(1, clog2(POOL)) as the width of the internal sample counter.
REQ-004 iCLK  input  1  clock; all state updates on its rising edge.
REQ-005 iRSTn  input  1  reset, asynchronous, active-low.
REQ-006 iCLR  input  1  synchronous flush; discards the partial window and any pending output.
REQ-007 iMODE  input  1  pooling operator: 0 = max (bitwise OR), 1 = min (bitwise AND).
REQ-008 iVALID  input  1  input sample valid.
REQ-009 oREADY  output  1  block can accept an input sample this cycle.
REQ-010 iDATA  input  CH  binary activation vector, one bit per channel.
REQ-011 iLAST  input  1  qualified by the accepted sample; closes the current window early (row end).
REQ-012 oVALID  output  1  pooled result valid.
REQ-013 iREADY  input  1  downstream accepts the pooled result.
REQ-014 oDATA  output  CH  pooled vector.
REQ-015 oPARTIAL  output  1  pooled result came from a window of fewer than POOL samples.

Function
REQ-016 Input accept SHALL be accept = iVALID & oREADY; output transfer SHALL be xfer = oVALID & iREADY.
REQ-017 oREADY SHALL be combinational: ~oVALID | iREADY, forced to 0 while iCLR = 1.
REQ-018 Counter cnt SHALL count accepted samples in the current window, 0..POOL-1.
REQ-019 On accept with cnt = 0: acc SHALL load iDATA, and the mode register SHALL latch iMODE.
REQ-020 On accept with cnt > 0: acc SHALL become acc | iDATA (latched mode 0) or acc & iDATA (latched mode 1); iMODE changes mid-window SHALL be ignored.
REQ-021 close = accept & (cnt = POOL-1 | iLAST).
REQ-022 On close: oDATA SHALL load the combined value (acc combined with iDATA, or iDATA alone when cnt = 0, using iMODE in that case); oVALID <= 1; cnt <= 0.
REQ-023 On close: oPARTIAL SHALL load 1 when cnt != POOL-1, else 0.
REQ-024 Latency: oVALID SHALL rise on the cycle after the closing accept.
REQ-025 On accept without close: cnt SHALL increment by 1.
REQ-026 xfer without close SHALL clear oVALID; xfer and close in the same cycle SHALL keep oVALID = 1 with new oDATA and oPARTIAL.
REQ-027 While oVALID & ~iREADY, oDATA and oPARTIAL SHALL hold stable and no sample SHALL be accepted.
REQ-028 A sample arriving while oVALID & ~iREADY SHALL wait on iVALID, with no loss and no duplication.
REQ-029 POOL = 1: every accepted sample SHALL close, with oDATA = iDATA and oPARTIAL = 0.
REQ-030 iLAST with cnt = POOL-1 SHALL close a full window with oPARTIAL = 0.
REQ-031 iCLR = 1 SHALL set cnt, acc and oVALID to 0 and SHALL override accept, close and xfer in that cycle.
REQ-032 Throughput SHALL be one sample per cycle while iREADY = 1.

Reset
REQ-033 iRSTn = 0 SHALL asynchronously clear cnt, acc, the mode register, oDATA, oVALID and oPARTIAL to 0.
REQ-034 After reset, oREADY SHALL be 1 and the first accepted sample SHALL start a new window.
REQ-035 Reset asserted mid-window or with oVALID = 1 SHALL discard all held data, with no output after release.

Verification (CH=4, POOL=4)
REQ-036 Max: iMODE=0, iREADY=1, samples 0001,0010,0000,1000 -> one cycle after 4th accept oVALID=1, oDATA=1011, oPARTIAL=0, oVALID low next cycle.
REQ-037 Min: iMODE=1 at first sample then toggled, samples 1111,1101,0111,1101 -> oDATA=0101, oPARTIAL=0.
REQ-038 Early close: 0100, then 0001 with iLAST=1 -> oDATA=0101, oPARTIAL=1; next 4 samples 1000,0,0,0 -> oDATA=1000, oPARTIAL=0.
REQ-039 Backpressure: iREADY=0 with result pending, iVALID=1 -> oREADY=0, oDATA stable; iREADY=1 -> xfer, same-cycle accept, and the next window's samples are unaffected.
REQ-040 Flush: 2 samples 1111,1111, iCLR pulse, then 0001,0000,0000,0010 -> oDATA=0011 only, no earlier output.
REQ-041 Async reset mid-window (cnt=2) and with oVALID=1 -> oVALID=0 immediately; a fresh 4-sample window after release gives the correct result.

Source files
------------

// File: rtl/bnn_maxpool_stream_if.sv
// rtl/bnn_maxpool_stream_if.sv - handshake bundle for the binary max/min pooling stream
`timescale 1ns/1ps
interface bnn_maxpool_stream_if #(
   parameter int CH = 16
);
   logic          iCLR;
   logic          iMODE;
   logic          iVALID;
   logic          oREADY;
   logic [CH-1:0] iDATA;
   logic          iLAST;
   logic          oVALID;
   logic          iREADY;
   logic [CH-1:0] oDATA;
   logic          oPARTIAL;

   modport slave (
      input  iCLR, iMODE, iVALID, iDATA, iLAST, iREADY,
      output oREADY, oVALID, oDATA, oPARTIAL
   );

   modport master (
      output iCLR, iMODE, iVALID, iDATA, iLAST, iREADY,
      input  oREADY, oVALID, oDATA, oPARTIAL
   );
endinterface

// File: rtl/bnn_maxpool_stream.sv
// rtl/bnn_maxpool_stream.sv - streaming OR/AND pooling of binary activation vectors over POOL samples
`timescale 1ns/1ps
module bnn_maxpool_stream #(
   parameter int CH   = 16,
   parameter int POOL = 4
) (
   input logic                 iCLK,
   input logic                 iRSTn,
   bnn_maxpool_stream_if.slave bus
);
   localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;

   logic [CW-1:0] cnt;
   logic [CH-1:0] acc;
   logic [CH-1:0] oData;
   logic [CH-1:0] merged;
   logic          modeReg;
   logic          oValid;
   logic          oPartial;
   logic          ready;
   logic          accept;
   logic          xfer;
   logic          firstSample;
   logic          lastSlot;
   logic          close;

   // A pending result that cannot leave blocks intake; a flush blocks everything.
   assign ready       = ~bus.iCLR & (~oValid | bus.iREADY);
   assign accept      = bus.iVALID & ready;
   assign xfer        = oValid & bus.iREADY & ~bus.iCLR;
   assign firstSample = (cnt == '0);
   assign lastSlot    = (cnt == CW'(POOL - 1));
   assign close       = accept & (lastSlot | bus.iLAST);

   always_comb begin
      merged = bus.iDATA;
      if (!firstSample) begin
         merged = modeReg ? (acc & bus.iDATA) : (acc | bus.iDATA);
      end
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         cnt      <= '0;
         acc      <= '0;
         modeReg  <= 1'b0;
         oData    <= '0;
         oValid   <= 1'b0;
         oPartial <= 1'b0;
      end else if (bus.iCLR) begin
         cnt    <= '0;
         acc    <= '0;
         oValid <= 1'b0;
      end else begin
         if (xfer) begin
            oValid <= 1'b0;
         end
         if (accept) begin
            acc <= merged;
            // Operator is fixed by the first sample of each window.
            if (firstSample) begin
               modeReg <= bus.iMODE;
            end
            if (close) begin
               cnt      <= '0;
               oData    <= merged;
               oValid   <= 1'b1;
               oPartial <= ~lastSlot;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.oREADY   = ready;
   assign bus.oVALID   = oValid;
   assign bus.oDATA    = oData;
   assign bus.oPARTIAL = oPartial;
endmodule
